program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Boot-time loader that sits directly upstream of the single-cycle MIPS processor's program memory. It receives a byte stream over a valid/ready handshake and assembles the bytes big-endian into 32-bit instructions. It writes each instruction into program memory at consecutive word-aligned byte addresses. It holds the processor in reset until the requested number of words has been written, then releases it.

Parameters:
MEMORY_DEPTH, 512, program memory depth in 32-bit words; largest legal WordCount.
COUNT_WIDTH, 10, width of WordCount; must be large enough to hold MEMORY_DEPTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
LoadStart  input  1  single-cycle request to start a load session.
WordCount  input  COUNT_WIDTH  number of words to load; sampled only when LoadStart is accepted.
ByteValid  input  1  ByteData holds a valid byte.
ByteData  input  8  incoming program byte.
ByteReady  output  1  loader accepts a byte this cycle.
ProgWrite  output  1  program-memory write strobe.
ProgAddress  output  32  program-memory byte address, word aligned (bits [1:0]=0).
ProgData  output  32  instruction word to write.
CpuReset  output  1  processor reset; high holds the processor in reset.
Busy  output  1  high in LOAD and WRITE.
Done  output  1  high in RUN.
Error  output  1  high in ERROR.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Reset values: state=IDLE, CpuReset=1, ByteReady=0, ProgWrite=0, ProgAddress=0, ProgData=0, Busy=0, Done=0, Error=0. Internal byte index=0, word counter=0.
- Reset asserted mid-session aborts the session immediately. Outputs take reset values asynchronously, with no partial-word write.
- States: IDLE, LOAD, WRITE, RUN, ERROR.
- IDLE:
  - CpuReset=1.
  - LoadStart with 1 <= WordCount <= MEMORY_DEPTH: latch WordCount, clear word counter and byte index, go to LOAD.
  - LoadStart with WordCount==0 or WordCount > MEMORY_DEPTH: go to ERROR.
- LOAD:
  - ByteReady=1.
  - A byte is accepted on a rising edge where ByteValid&&ByteReady.
  - Byte index 0 goes to ProgData[31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - After the 4th accepted byte: byte index returns to 0, go to WRITE.
  - ByteValid low: hold; no timeout.
- WRITE:
  - Lasts exactly one cycle. ProgWrite=1, ByteReady=0.
  - ProgAddress = word_counter*4, with the upper bits zero.
  - Next edge: word_counter increments.
  - If the incremented count equals the latched WordCount, go to RUN; otherwise go to LOAD.
- RUN:
  - CpuReset=0 and Done=1, starting on the first cycle after the last WRITE.
  - LoadStart (valid or invalid count) is evaluated exactly as in IDLE.
  - The transition out of RUN raises CpuReset on the same edge.
- ERROR:
  - CpuReset=1, Error=1, ByteReady=0.
  - Only a LoadStart with a legal count leaves ERROR (to LOAD). Error clears on that edge.
- LoadStart is ignored in LOAD and WRITE.
- ByteValid outside LOAD is ignored; no byte is consumed.
- ProgData and ProgAddress hold their last values outside WRITE. Memory must qualify writes with ProgWrite.
- Throughput: minimum 5 cycles per word (4 byte accepts + 1 write cycle).
- Word counter never exceeds MEMORY_DEPTH. The last address written is (WordCount-1)*4.

Test Plan:
- Reset then idle: reset pulse, no stimulus for 10 cycles -> CpuReset=1, ByteReady=0, ProgWrite=0, Done=0, Error=0 throughout.
- Two-word load, ByteValid held high: LoadStart with WordCount=2, bytes 20 08 00 05 24 09 00 0A -> ProgWrite pulses twice, each 1 cycle wide. First pulse: ProgAddress=0x0, ProgData=0x20080005. Second pulse: ProgAddress=0x4, ProgData=0x2409000A. CpuReset falls and Done rises the cycle after the second pulse. Total 10 cycles from first accept.
- Gapped stream: same load with ByteValid low for 3 cycles between every byte -> identical writes and data; no byte lost or duplicated.
- Illegal counts: LoadStart with WordCount=0 -> Error=1, CpuReset=1. LoadStart with WordCount=513 -> Error=1. Then LoadStart with WordCount=1 and bytes DE AD BE EF -> Error clears, one write of 0xDEADBEEF at address 0, then RUN.
- Mid-load reset: WordCount=3; assert reset asynchronously after 6 bytes -> outputs return to reset values immediately and no write of word 1 occurs. Restart load of 3 words -> addresses 0x0, 0x4, 0x8.
- Reload from RUN: after a completed load, LoadStart with WordCount=MEMORY_DEPTH -> CpuReset rises on that edge, Busy=1. 512 writes follow, the last at ProgAddress=0x7FC, then RUN. A LoadStart issued mid-load is ignored.

Source files
------------

// File: rtl/program_loader_if.sv
// Boot-loader bus: byte-stream handshake in, program-memory write port and CPU control out.
interface program_loader_if #(
    parameter int unsigned COUNT_WIDTH = 10
);
    logic                   LoadStart;
    logic [COUNT_WIDTH-1:0] WordCount;
    logic                   ByteValid;
    logic [7:0]             ByteData;
    logic                   ByteReady;
    logic                   ProgWrite;
    logic [31:0]            ProgAddress;
    logic [31:0]            ProgData;
    logic                   CpuReset;
    logic                   Busy;
    logic                   Done;
    logic                   Error;

    modport slave (
        input  LoadStart, WordCount, ByteValid, ByteData,
        output ByteReady, ProgWrite, ProgAddress, ProgData, CpuReset, Busy, Done, Error
    );

    modport master (
        output LoadStart, WordCount, ByteValid, ByteData,
        input  ByteReady, ProgWrite, ProgAddress, ProgData, CpuReset, Busy, Done, Error
    );
endinterface

// File: rtl/program_loader.sv
// Assembles a big-endian byte stream into 32-bit words, writes them to program
// memory at consecutive word addresses and releases the CPU once all are written.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 512,
    parameter int unsigned COUNT_WIDTH  = 10
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] word_q, word_d;
    logic [1:0]             idx_q, idx_d;
    logic [23:0]            asm_q, asm_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            addr_q, addr_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   prog_write_q, prog_write_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   count_legal;

    assign count_legal = (bus.WordCount != '0) && (bus.WordCount <= MAX_COUNT);

    // Next state, datapath and output decode; outputs follow the next state so they are registered.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        data_d  = data_q;
        addr_d  = addr_q;

        unique case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (bus.LoadStart) begin
                    if (count_legal) begin
                        count_d = bus.WordCount;
                        word_d  = '0;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_LOAD: begin
                if (bus.ByteValid && byte_ready_q) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        data_d  = {asm_q, bus.ByteData};
                        addr_d  = 32'({word_q, 2'b00});
                        state_d = S_WRITE;
                    end else begin
                        asm_d = {asm_q[15:0], bus.ByteData};
                    end
                end
            end
            S_WRITE: begin
                word_d  = word_q + COUNT_WIDTH'(1);
                state_d = (word_d == count_q) ? S_RUN : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_LOAD);
        prog_write_d = (state_d == S_WRITE);
        cpu_reset_d  = (state_d != S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d       = (state_d == S_RUN);
        error_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            prog_write_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            byte_ready_q <= byte_ready_d;
            prog_write_q <= prog_write_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.ByteReady   = byte_ready_q;
    assign bus.ProgWrite   = prog_write_q;
    assign bus.ProgAddress = addr_q;
    assign bus.ProgData    = data_q;
    assign bus.CpuReset    = cpu_reset_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Error       = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, loads with and without gaps, illegal counts,
// mid-load reset and a full-depth reload from RUN.
module tb_program_loader;
    logic clk = 1'b0;
    logic reset;

    program_loader_if #(.COUNT_WIDTH(10)) intf ();

    program_loader #(.MEMORY_DEPTH(512), .COUNT_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int first_acc = -1;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    // Edge monitor: values read here are those held just before the edge.
    always @(posedge clk) begin
        cyc++;
        if (intf.ProgWrite) begin
            wr_addr.push_back(intf.ProgAddress);
            wr_data.push_back(intf.ProgData);
            wr_cyc.push_back(cyc);
        end
        if (intf.ByteValid && intf.ByteReady && first_acc < 0) first_acc = cyc;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        first_acc = -1;
    endtask

    task automatic do_start(input logic [9:0] count);
        @(negedge clk);
        intf.LoadStart = 1'b1;
        intf.WordCount = count;
        @(posedge clk);
        #1;
        intf.LoadStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        @(negedge clk);
        intf.ByteValid = 1'b1;
        intf.ByteData  = b;
        while (!intf.ByteReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL byte_accept_timeout: ByteReady=%b expected 1", intf.ByteReady);
        end
        @(posedge clk);
        #1;
        intf.ByteValid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        int t = 0;
        done_cyc = -1;
        while (t < budget) begin
            @(posedge clk);
            #1;
            t++;
            if (intf.Done) begin
                done_cyc = cyc;
                break;
            end
        end
        n_cmp++;
        if (done_cyc < 0) begin
            n_err++;
            $display("FAIL done_timeout: Done=%b expected 1 within %0d cycles", intf.Done, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({intf.CpuReset, intf.ByteReady, intf.ProgWrite, intf.Busy, intf.Done, intf.Error} !== 6'b100000
            || intf.ProgAddress !== 32'h0 || intf.ProgData !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: flags=%b addr=%h data=%h expected flags=100000 addr=0 data=0",
                     {intf.CpuReset, intf.ByteReady, intf.ProgWrite, intf.Busy, intf.Done, intf.Error},
                     intf.ProgAddress, intf.ProgData);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({intf.CpuReset, intf.ByteReady, intf.ProgWrite, intf.Done, intf.Error} !== 5'b10000) begin
                n_err++;
                $display("FAIL idle_cycle_%0d: flags=%b expected 10000", i,
                         {intf.CpuReset, intf.ByteReady, intf.ProgWrite, intf.Done, intf.Error});
            end
        end
    endtask

    task automatic check_two_words(input string tag);
        n_cmp++;
        if (wr_addr.size() != 2) begin
            n_err++;
            $display("FAIL %s_write_count: got %0d expected 2", tag, wr_addr.size());
        end else begin
            n_cmp++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h20080005) begin
                n_err++;
                $display("FAIL %s_word0: addr=%h data=%h expected 00000000 20080005", tag, wr_addr[0], wr_data[0]);
            end
            n_cmp++;
            if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h2409000A) begin
                n_err++;
                $display("FAIL %s_word1: addr=%h data=%h expected 00000004 2409000a", tag, wr_addr[1], wr_data[1]);
            end
        end
    endtask

    task automatic test_two_word();
        int done_cyc;
        clear_log();
        do_start(10'd2);
        n_cmp++;
        if (intf.Busy !== 1'b1 || intf.ByteReady !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy: Busy=%b ByteReady=%b expected 1 1", intf.Busy, intf.ByteReady);
        end
        send_word(32'h20080005, 0);
        send_word(32'h2409000A, 0);
        wait_done(20, done_cyc);
        check_two_words("b2b");
        n_cmp++;
        if (done_cyc - first_acc != 9) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d edges expected 9", done_cyc - first_acc);
        end
        if (wr_cyc.size() == 2) begin
            n_cmp++;
            if (done_cyc != wr_cyc[1] || wr_cyc[1] - wr_cyc[0] != 5) begin
                n_err++;
                $display("FAIL b2b_write_timing: w0=%0d w1=%0d done=%0d expected spacing 5 and done at w1",
                         wr_cyc[0], wr_cyc[1], done_cyc);
            end
        end
        n_cmp++;
        if (intf.CpuReset !== 1'b0 || intf.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_run: CpuReset=%b Busy=%b expected 0 0", intf.CpuReset, intf.Busy);
        end
    endtask

    task automatic test_gapped();
        int done_cyc;
        clear_log();
        do_start(10'd2);
        send_word(32'h20080005, 3);
        send_word(32'h2409000A, 3);
        wait_done(40, done_cyc);
        check_two_words("gap");
    endtask

    task automatic test_illegal();
        int done_cyc;
        clear_log();
        do_start(10'd0);
        n_cmp++;
        if (intf.Error !== 1'b1 || intf.CpuReset !== 1'b1 || intf.ByteReady !== 1'b0) begin
            n_err++;
            $display("FAIL count0_error: Error=%b CpuReset=%b ByteReady=%b expected 1 1 0",
                     intf.Error, intf.CpuReset, intf.ByteReady);
        end
        do_start(10'd513);
        n_cmp++;
        if (intf.Error !== 1'b1 || intf.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL count513_error: Error=%b Busy=%b expected 1 0", intf.Error, intf.Busy);
        end
        do_start(10'd1);
        n_cmp++;
        if (intf.Error !== 1'b0 || intf.Busy !== 1'b1) begin
            n_err++;
            $display("FAIL error_recover: Error=%b Busy=%b expected 0 1", intf.Error, intf.Busy);
        end
        send_word(32'hDEADBEEF, 0);
        wait_done(10, done_cyc);
        n_cmp++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL recover_write: count=%0d addr=%h data=%h expected 1 00000000 deadbeef",
                     wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx,
                     (wr_data.size() > 0) ? wr_data[0] : 32'hx);
        end
    endtask

    task automatic test_mid_reset();
        int done_cyc;
        clear_log();
        do_start(10'd3);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({intf.CpuReset, intf.ByteReady, intf.ProgWrite, intf.Busy, intf.Done, intf.Error} !== 6'b100000
            || intf.ProgAddress !== 32'h0 || intf.ProgData !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: flags=%b addr=%h data=%h expected flags=100000 addr=0 data=0",
                     {intf.CpuReset, intf.ByteReady, intf.ProgWrite, intf.Busy, intf.Done, intf.Error},
                     intf.ProgAddress, intf.ProgData);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        n_cmp++;
        if (wr_addr.size() != 1) begin
            n_err++;
            $display("FAIL mid_reset_writes: got %0d writes expected 1", wr_addr.size());
        end
        clear_log();
        do_start(10'd3);
        send_word(32'hA0A1A2A3, 0);
        send_word(32'hB0B1B2B3, 0);
        send_word(32'hC0C1C2C3, 0);
        wait_done(20, done_cyc);
        n_cmp++;
        if (wr_addr.size() != 3 || wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h4 || wr_addr[2] !== 32'h8
            || wr_data[2] !== 32'hC0C1C2C3) begin
            n_err++;
            $display("FAIL restart_addresses: count=%0d expected 3 writes at 0,4,8 with last data c0c1c2c3",
                     wr_addr.size());
        end
    endtask

    task automatic test_reload();
        int done_cyc;
        int bad;
        logic [31:0] w;
        clear_log();
        n_cmp++;
        if (intf.CpuReset !== 1'b0 || intf.Done !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reload_run: CpuReset=%b Done=%b expected 0 1", intf.CpuReset, intf.Done);
        end
        do_start(10'd512);
        n_cmp++;
        if (intf.CpuReset !== 1'b1 || intf.Busy !== 1'b1 || intf.Done !== 1'b0) begin
            n_err++;
            $display("FAIL reload_start: CpuReset=%b Busy=%b Done=%b expected 1 1 0",
                     intf.CpuReset, intf.Busy, intf.Done);
        end
        for (int k = 0; k < 512; k++) begin
            w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            send_word(w, 0);
            if (k == 25) begin
                do_start(10'd1);
                n_cmp++;
                if (intf.Busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL ignored_loadstart: Busy=%b expected 1", intf.Busy);
                end
            end
        end
        wait_done(20, done_cyc);
        n_cmp++;
        if (wr_addr.size() != 512) begin
            n_err++;
            $display("FAIL reload_count: got %0d writes expected 512", wr_addr.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 512; k++) begin
                w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
                if (wr_addr[k] !== 32'(4*k) || wr_data[k] !== w) bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL reload_contents: %0d bad words expected 0", bad);
            end
            n_cmp++;
            if (wr_addr[511] !== 32'h7FC) begin
                n_err++;
                $display("FAIL reload_last_addr: got %h expected 000007fc", wr_addr[511]);
            end
        end
        n_cmp++;
        if (intf.CpuReset !== 1'b0 || intf.Done !== 1'b1) begin
            n_err++;
            $display("FAIL reload_run: CpuReset=%b Done=%b expected 0 1", intf.CpuReset, intf.Done);
        end
    endtask

    initial begin
        reset = 1'b1;
        intf.LoadStart = 1'b0;
        intf.WordCount = '0;
        intf.ByteValid = 1'b0;
        intf.ByteData  = '0;
        test_reset();
        test_two_word();
        test_gapped();
        test_illegal();
        test_mid_reset();
        test_reload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
